// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, the imem request/ready handshake,
// next-PC selection (branch > jump > sequential) and the IF/ID register.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    input  logic [31:0] adder_sum,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redirect_pc;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        accept;

    // The EX-stage branch is older than the ID-stage jump, so it wins.
    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? branch_target : jump_target;

    assign adder_a   = pc;
    assign adder_b   = PC_STEP;
    assign imem_addr = pc;

    // A request issued in FETCH must be held until accepted, so SQUASH keeps it up.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            BOOT:    imem_req = 1'b0;
            FETCH:   imem_req = !stall;
            SQUASH:  imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    assign accept = (state == FETCH) && imem_req && imem_ready && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            redirect_pc <= 32'h0000_0000;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        if (imem_req && !imem_ready) begin
                            redirect_pc <= redirect_target;
                            state       <= SQUASH;
                        end else begin
                            pc <= redirect_target;
                        end
                    end else if (imem_req && imem_ready) begin
                        pc <= adder_sum;
                    end
                end
                SQUASH: begin
                    if (imem_ready) begin
                        pc    <= redirect ? redirect_target : redirect_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        redirect_pc <= redirect_target;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    // IF/ID: invalidate on flush/redirect, freeze on stall, else load or bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_valid    <= 1'b0;
            if_id_instr    <= 32'h0000_0000;
            if_id_pc       <= 32'h0000_0000;
            if_id_pc_plus4 <= 32'h0000_0000;
        end else if (flush || redirect) begin
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if_id_valid <= if_id_valid;
        end else if (accept) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= imem_rdata;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= adder_sum;
        end else begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed + randomized bench for pc_fetch_unit: two instances (default and
// wrap-around reset PC) checked every cycle against a cycle-level reference.
module tb_pc_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        imem_ready = 1'b1;

    logic [31:0] adder_a [2];
    logic [31:0] adder_b [2];
    logic [31:0] adder_sum [2];
    logic        imem_req [2];
    logic [31:0] imem_addr [2];
    logic [31:0] imem_rdata [2];
    logic        if_id_valid [2];
    logic [31:0] if_id_instr [2];
    logic [31:0] if_id_pc [2];
    logic [31:0] if_id_pc_plus4 [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External adder and instruction memory (instruction = address ^ K).
    assign adder_sum[0]  = adder_a[0] + adder_b[0];
    assign adder_sum[1]  = adder_a[1] + adder_b[1];
    assign imem_rdata[0] = imem_addr[0] ^ K;
    assign imem_rdata[1] = imem_addr[1] ^ K;

    pc_fetch_unit u_dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .adder_a(adder_a[0]), .adder_b(adder_b[0]), .adder_sum(adder_sum[0]),
        .imem_req(imem_req[0]), .imem_addr(imem_addr[0]),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata[0]),
        .if_id_valid(if_id_valid[0]), .if_id_instr(if_id_instr[0]),
        .if_id_pc(if_id_pc[0]), .if_id_pc_plus4(if_id_pc_plus4[0])
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) u_dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .adder_a(adder_a[1]), .adder_b(adder_b[1]), .adder_sum(adder_sum[1]),
        .imem_req(imem_req[1]), .imem_addr(imem_addr[1]),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata[1]),
        .if_id_valid(if_id_valid[1]), .if_id_instr(if_id_instr[1]),
        .if_id_pc(if_id_pc[1]), .if_id_pc_plus4(if_id_pc_plus4[1])
    );

    // Reference model: "booting", "waiting out a squashed fetch", pending target.
    logic [31:0] m_pc [2], m_rpc [2], m_instr [2], m_ipc [2], m_ip4 [2];
    bit          m_boot [2], m_sq [2], m_v [2];
    logic [31:0] n_pc [2], n_rpc [2], n_instr [2], n_ipc [2], n_ip4 [2];
    bit          n_boot [2], n_sq [2], n_v [2];

    function automatic logic [31:0] rst_pc(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    function automatic bit m_req(input int i);
        if (m_boot[i]) return 1'b0;
        if (m_sq[i]) return 1'b1;
        return !stall;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_boot[i] = 1; m_sq[i] = 0; m_pc[i] = rst_pc(i); m_rpc[i] = 0;
            m_v[i] = 0; m_instr[i] = 0; m_ipc[i] = 0; m_ip4[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        for (int i = 0; i < 2; i++) begin
            chk("rst_req", i, {31'b0, imem_req[i]}, 32'h0);
            chk("rst_addr", i, imem_addr[i], rst_pc(i));
            chk("rst_valid", i, {31'b0, if_id_valid[i]}, 32'h0);
            chk("rst_instr", i, if_id_instr[i], 32'h0);
            chk("rst_ifpc", i, if_id_pc[i], 32'h0);
            chk("rst_ifp4", i, if_id_pc_plus4[i], 32'h0);
        end
    endtask

    // One cycle: compare against model, predict next state, clock, commit.
    task automatic step();
        bit          redir, req, rdy;
        logic [31:0] tgt;
        #1;
        redir = branch_taken | jump;
        tgt   = branch_taken ? branch_target : jump_target;
        rdy   = imem_ready;
        for (int i = 0; i < 2; i++) begin
            req = m_req(i);
            chk("imem_req", i, {31'b0, imem_req[i]}, {31'b0, req});
            chk("imem_addr", i, imem_addr[i], m_pc[i]);
            chk("adder_a", i, adder_a[i], m_pc[i]);
            chk("adder_b", i, adder_b[i], 32'd4);
            chk("valid", i, {31'b0, if_id_valid[i]}, {31'b0, m_v[i]});
            if (m_v[i]) begin
                chk("instr", i, if_id_instr[i], m_instr[i]);
                chk("if_pc", i, if_id_pc[i], m_ipc[i]);
                chk("if_pc4", i, if_id_pc_plus4[i], m_ip4[i]);
            end
            n_boot[i] = m_boot[i]; n_sq[i] = m_sq[i]; n_pc[i] = m_pc[i]; n_rpc[i] = m_rpc[i];
            n_v[i] = m_v[i]; n_instr[i] = m_instr[i]; n_ipc[i] = m_ipc[i]; n_ip4[i] = m_ip4[i];
            if (m_boot[i]) begin
                n_boot[i] = 0;
            end else if (m_sq[i]) begin
                if (redir) n_rpc[i] = tgt;
                if (rdy) begin
                    n_pc[i] = redir ? tgt : m_rpc[i];
                    n_sq[i] = 0;
                end
            end else if (redir) begin
                if (req && !rdy) begin
                    n_sq[i] = 1; n_rpc[i] = tgt;
                end else begin
                    n_pc[i] = tgt;
                end
            end else if (req && rdy) begin
                n_pc[i] = m_pc[i] + 32'd4;
            end
            if (flush || redir) n_v[i] = 0;
            else if (stall) n_v[i] = m_v[i];
            else if (!m_boot[i] && !m_sq[i] && req && rdy) begin
                n_v[i] = 1; n_instr[i] = m_pc[i] ^ K; n_ipc[i] = m_pc[i]; n_ip4[i] = m_pc[i] + 32'd4;
            end else n_v[i] = 0;
        end
        if (if_id_valid[0])
            $display("t=%0t ifid0 pc=%h instr=%h pc4=%h", $time, if_id_pc[0], if_id_instr[0], if_id_pc_plus4[0]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_boot[i] = n_boot[i]; m_sq[i] = n_sq[i]; m_pc[i] = n_pc[i]; m_rpc[i] = n_rpc[i];
            m_v[i] = n_v[i]; m_instr[i] = n_instr[i]; m_ipc[i] = n_ipc[i]; m_ip4[i] = n_ip4[i];
        end
    endtask

    task automatic clear_ctl();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_values();
        @(negedge clk);
        reset = 0;

        // Plan 1: BOOT bubble, then sequential fetch.
        imem_ready = 1;
        #1 chk("boot_req", 0, {31'b0, imem_req[0]}, 32'h0);
        step();
        #1 chk("seq_addr0", 0, imem_addr[0], 32'h0);
        step();
        #1 chk("seq_addr4", 0, imem_addr[0], 32'h4);
        chk("trail_pc", 0, if_id_pc[0], 32'h0);
        chk("trail_p4", 0, if_id_pc_plus4[0], 32'h4);
        step();

        // Plan 2: wait states at pc=8.
        imem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("wait_addr", 0, imem_addr[0], 32'h8);
            if (k > 0) chk("wait_bubble", 0, {31'b0, if_id_valid[0]}, 32'h0);
            step();
        end
        imem_ready = 1;
        step();
        #1 chk("after_wait", 0, imem_addr[0], 32'hC);
        step();

        // Plan 3: stall at pc=0x10.
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            #1 chk("stall_req", 0, {31'b0, imem_req[0]}, 32'h0);
            chk("stall_addr", 0, imem_addr[0], 32'h10);
            step();
        end
        stall = 0;
        step();

        // Plan 4: branch while the fetch at 0x14 is outstanding.
        imem_ready = 0; branch_taken = 1; branch_target = 32'h100;
        step();
        branch_taken = 0;
        #1 chk("squash_addr", 0, imem_addr[0], 32'h14);
        chk("squash_req", 0, {31'b0, imem_req[0]}, 32'h1);
        step();
        imem_ready = 1;
        step();
        #1 chk("redir_addr", 0, imem_addr[0], 32'h100);
        chk("squash_drop", 0, {31'b0, if_id_valid[0]}, 32'h0);
        step();

        // Plan 5: branch + jump + stall together.
        stall = 1; branch_taken = 1; branch_target = 32'h200; jump = 1; jump_target = 32'h300;
        step();
        clear_ctl();
        #1 chk("prio_addr", 0, imem_addr[0], 32'h200);
        chk("prio_inval", 0, {31'b0, if_id_valid[0]}, 32'h0);
        step();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_target   = $urandom & 32'hFFFF_FFFC;
            imem_ready    = ($urandom_range(0, 2) != 0);
            step();
        end
        clear_ctl();

        // Plan 6: wrap-around from RESET_PC=FFFF_FFF8, then reset mid-wait.
        @(negedge clk);
        reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
        imem_ready = 1;
        step();
        #1 chk("wrap_a", 1, imem_addr[1], 32'hFFFF_FFF8);
        step();
        #1 chk("wrap_b", 1, imem_addr[1], 32'hFFFF_FFFC);
        step();
        #1 chk("wrap_c", 1, imem_addr[1], 32'h0000_0000);
        chk("wrap_p4", 1, if_id_pc_plus4[1], 32'h0000_0000);
        step();
        imem_ready = 0;
        step();
        step();
        reset = 1;
        #1 check_reset_values();
        model_reset();
        @(negedge clk);
        reset = 0;
        imem_ready = 1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
